k10_axil_master: RTL and testbench
==================================

// Module: k10_axil_master
// PURPOSE
//   Single-outstanding AXI4-Lite master that converts a simple valid/ready request port into
//   AXI4-Lite read or write transactions and returns one response per request. Used by
//   bench-side and debug initiators to drive K10 AXI4-Lite slaves (sim controller, UART, timers).
//   Write address and data are issued together; the B/R response is returned with an error flag.
// PARAMETERS
//   AXI_PROT    3'b000  constant driven on m_axi_awprot / m_axi_arprot
//   WORD_ALIGN  1       1: force addr[1:0]=2'b00 on AW/AR; 0: pass the address through unchanged
// PORTS
//   i_clk          in   1   clock, rising edge
//   i_rst_n        in   1   asynchronous reset, active low
//   i_req_valid    in   1   request valid
//   o_req_ready    out  1   request accepted when valid&&ready
//   i_req_we       in   1   1 = write, 0 = read
//   i_req_addr     in   32  byte address
//   i_req_wdata    in   32  write data
//   i_req_wstrb    in   4   write byte strobes
//   o_rsp_valid    out  1   response valid
//   i_rsp_ready    in   1   response consumed when valid&&ready
//   o_rsp_rdata    out  32  read data; 0 for writes
//   o_rsp_err      out  1   1 when BRESP/RRESP != OKAY
//   m_axi_aw{addr[32],prot[3],valid} out, m_axi_awready in  write address channel
//   m_axi_w{data[32],strb[4],valid}  out, m_axi_wready  in  write data channel
//   m_axi_bresp[2] in, m_axi_bvalid in, m_axi_bready out    write response channel
//   m_axi_ar{addr[32],prot[3],valid} out, m_axi_arready in  read address channel
//   m_axi_rdata[32] in, m_axi_rresp[2] in, m_axi_rvalid in, m_axi_rready out  read data channel
// BEHAVIOUR
// - Reset values: all valid and ready outputs 0; o_rsp_rdata 0; o_rsp_err 0; FSM in IDLE.
//   On reset mid-transaction, all valids drop immediately and the transaction is abandoned.
// - All outputs are registered, except o_req_ready, m_axi_bready and m_axi_rready, which
//   are decoded from the FSM state.
// - FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
//   IDLE:          o_req_ready=1. On accept, latch the request and go to WR_ADDR_DATA (we=1) or RD_ADDR (we=0).
//                  awvalid/wvalid or arvalid rise on the next cycle.
//   WR_ADDR_DATA:  awvalid and wvalid are held independently. Each drops the cycle after its own
//                  handshake. AW and W may complete in the same cycle or in either order.
//                  When both have completed, go to WR_RESP.
//   WR_RESP:       bready=1. On bvalid, capture err=(bresp!=2'b00), set rdata=0, go to RSP.
//   RD_ADDR:       arvalid held until arready, then go to RD_DATA.
//   RD_DATA:       rready=1. On rvalid, capture rdata and err=(rresp!=2'b00), go to RSP.
//   RSP:           o_rsp_valid=1, with rdata/err stable until i_rsp_ready, then return to IDLE.
// - A valid is never deasserted before its ready, and address/data/strb/prot are stable while valid.
// - bready and rready are never asserted outside WR_RESP and RD_DATA; stray B/R beats are ignored.
// - Exactly one transaction is outstanding. The next request can be accepted no earlier than
//   the cycle after the response handshake.
// - Minimum latency with zero-wait slaves: accept at cycle 0; AW/W valid at cycle 1;
//   B handshake at cycle 2; o_rsp_valid at cycle 3. Reads have the same timing.
// - A response with i_rsp_ready already high completes in a single RSP cycle.
// - wstrb=0 is still issued as a normal write; the master does not filter it.
// TESTING
// 1) Write addr=0x04, wdata=0x41, wstrb=4'hF, slave ready at once with BRESP=OKAY
//    -> awaddr=0x04 and wdata=0x41 at cycle 1; o_rsp_valid at cycle 3 with err=0 and rdata=0.
// 2) Write with awready delayed 3 cycles and wready immediate
//    -> wvalid drops after 1 cycle, awvalid is held 4 cycles, a single B is accepted, response ok.
// 3) Read addr=0x0B with WORD_ALIGN=1, slave returns RDATA=0x0000_1234, RRESP=OKAY
//    -> araddr=0x08; rsp rdata=0x0000_1234, err=0.
// 4) Read with RRESP=2'b10 (SLVERR) -> o_rsp_err=1; the next write with BRESP=OKAY -> err=0.
// 5) i_rsp_ready held low 5 cycles -> rsp holds stable, o_req_ready=0, no new AXI valids issued.
// 6) Assert i_rst_n=0 while awvalid is high -> all valids are 0 during reset; IDLE with
//    o_req_ready=1 after release; bvalid pulses arriving outside WR_RESP get no bready.

Source files
------------

// File: rtl/k10_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : k10_axil_master
// Description : Single-outstanding AXI4-Lite master bridging a valid/ready
//               request/response port onto AXI4-Lite read/write channels.
// Revision    : 1.0 - initial release
// ============================================================================
module k10_axil_master #(
    parameter logic [2:0] AXI_PROT   = 3'b000,
    parameter int         WORD_ALIGN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // request / response port
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    // write address channel
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    // write data channel
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    // write response channel
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    // read address channel
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    // read data channel
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RSP          = 3'd5
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [3:0]  wstrb_q,     wstrb_d;
    logic        awvalid_q,   awvalid_d;
    logic        wvalid_q,    wvalid_d;
    logic        arvalid_q,   arvalid_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;

    logic [31:0] req_addr_aligned;

    assign req_addr_aligned = (WORD_ALIGN != 0) ? {i_req_addr[31:2], 2'b00} : i_req_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    addr_d  = req_addr_aligned;
                    wdata_d = i_req_wdata;
                    wstrb_d = i_req_wstrb;
                    if (i_req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave once neither is still pending
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    rsp_err_d   = (m_axi_bresp != 2'b00);
                    rsp_rdata_d = 32'h0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rsp_err_d   = (m_axi_rresp != 2'b00);
                    rsp_rdata_d = m_axi_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is masked while reset is held so every ready output reads 0 in reset
    assign o_req_ready   = (state_q == IDLE) && i_rst_n;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_rready  = (state_q == RD_DATA);

    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = AXI_PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = AXI_PROT;
    assign m_axi_arvalid = arvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_k10_axil_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_k10_axil_master
// Description : Directed self-checking bench for k10_axil_master with a
//               configurable-latency AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_k10_axil_master;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = 32'h0;
    logic [31:0] i_req_wdata = 32'h0;
    logic [3:0]  i_req_wstrb = 4'h0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = 32'h0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    k10_axil_master #(.AXI_PROT(3'b000), .WORD_ALIGN(1)) u_dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_we      (i_req_we),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .i_req_wstrb   (i_req_wstrb),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_rdata   (o_rsp_rdata),
        .o_rsp_err     (o_rsp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    // slave knobs, written by the stimulus process
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
    logic [31:0] rdata_k = 32'h0;
    logic        stray_b = 1'b0;

    // slave model state and observation counters
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_got = 0, w_got = 0, pend_b = 0, pend_r = 0;
    logic        aw_prev = 0, aw_stall = 0, w_stall = 0, ar_stall = 0;
    logic [31:0] aw_stall_addr = 0, w_stall_data = 0, ar_stall_addr = 0;
    int          aw_hi_total = 0, w_hi_total = 0, b_hs_total = 0, r_hs_total = 0;
    int          aw_rise_cyc = 0, viol = 0;
    logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
    logic [3:0]  last_wstrb = 0;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_got = 0; w_got = 0; pend_b = 0; pend_r = 0;
            aw_prev = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
        end else begin
            // a stalled valid must persist with unchanged payload
            if (aw_stall && (!m_axi_awvalid || m_axi_awaddr !== aw_stall_addr)) viol++;
            if (w_stall && (!m_axi_wvalid || m_axi_wdata !== w_stall_data)) viol++;
            if (ar_stall && (!m_axi_arvalid || m_axi_araddr !== ar_stall_addr)) viol++;

            m_axi_bvalid = pend_b | stray_b;
            m_axi_bresp  = bresp_k;
            m_axi_rvalid = pend_r;
            m_axi_rdata  = pend_r ? rdata_k : 32'h0;
            m_axi_rresp  = rresp_k;

            m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
            m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_delay);
            m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_delay);

            if (m_axi_awvalid) begin
                aw_hi_total++;
                if (!aw_prev) aw_rise_cyc = cyc;
            end
            aw_prev = m_axi_awvalid;
            if (m_axi_wvalid) w_hi_total++;

            aw_stall = m_axi_awvalid && !m_axi_awready;
            aw_stall_addr = m_axi_awaddr;
            w_stall = m_axi_wvalid && !m_axi_wready;
            w_stall_data = m_axi_wdata;
            ar_stall = m_axi_arvalid && !m_axi_arready;
            ar_stall_addr = m_axi_araddr;

            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt = 0; aw_got = 1; last_awaddr = m_axi_awaddr;
            end else if (m_axi_awvalid) aw_cnt++;
            if (m_axi_wvalid && m_axi_wready) begin
                w_cnt = 0; w_got = 1; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
            end else if (m_axi_wvalid) w_cnt++;

            if (m_axi_bvalid && m_axi_bready && pend_b) begin
                b_hs_total++; pend_b = 0;
            end
            if (aw_got && w_got) begin
                pend_b = 1; aw_got = 0; w_got = 0;
            end

            if (m_axi_rvalid && m_axi_rready) begin
                r_hs_total++; pend_r = 0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt = 0; pend_r = 1; last_araddr = m_axi_araddr;
            end else if (m_axi_arvalid) ar_cnt++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // one request/response round trip; rsp_wait = cycles i_rsp_ready stays low
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int rsp_wait,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int acc);
        int   n;
        logic bad;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr;
        i_req_wdata = wdata; i_req_wstrb = strb; i_rsp_ready = 1'b0;
        n = 0;
        while (!o_req_ready && n < 50) begin @(negedge i_clk); n++; end
        if (n >= 50) check({tag, "_req_timeout"}, 32'd1, 32'd0);
        acc = cyc;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        n = 0;
        while (!o_rsp_valid && n < 100) begin @(negedge i_clk); n++; end
        if (n >= 100) check({tag, "_rsp_timeout"}, 32'd1, 32'd0);
        lat = cyc - acc; rdata = o_rsp_rdata; err = o_rsp_err;
        bad = 1'b0;
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge i_clk);
            if (!o_rsp_valid || o_rsp_rdata !== rdata || o_rsp_err !== err || o_req_ready ||
                m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) bad = 1'b1;
        end
        if (rsp_wait > 0) check({tag, "_rsp_hold"}, {31'd0, bad}, 32'd0);
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, {31'd0, o_rsp_valid}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, acc, aw0, w0, b0, r0;

    initial begin
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_valids", {28'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, o_rsp_valid}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
        check("rst_rsp", {o_rsp_rdata[30:0], o_rsp_err}, 32'd0);
        check("rst_brready", {30'd0, m_axi_bready, m_axi_rready}, 32'd0);

        // T1: zero-wait write
        aw0 = aw_hi_total; b0 = b_hs_total;
        do_req("t1", 1'b1, 32'h04, 32'h41, 4'hF, 0, rd, er, lat, acc);
        check("t1_lat", 32'(lat), 32'd3);
        check("t1_aw_rise", 32'(aw_rise_cyc - acc), 32'd1);
        check("t1_aw_cycles", 32'(aw_hi_total - aw0), 32'd1);
        check("t1_awaddr", last_awaddr, 32'h04);
        check("t1_wdata", last_wdata, 32'h41);
        check("t1_wstrb", {28'd0, last_wstrb}, 32'hF);
        check("t1_err_rdata", {rd[30:0], er}, 32'd0);
        check("t1_b_count", 32'(b_hs_total - b0), 32'd1);
        check("t1_prot", {26'd0, m_axi_awprot, m_axi_arprot}, 32'd0);

        // T2: AW delayed three cycles, W immediate
        aw_delay = 3;
        aw0 = aw_hi_total; w0 = w_hi_total; b0 = b_hs_total;
        do_req("t2", 1'b1, 32'h10, 32'hA5A5_0001, 4'h3, 0, rd, er, lat, acc);
        check("t2_aw_cycles", 32'(aw_hi_total - aw0), 32'd4);
        check("t2_w_cycles", 32'(w_hi_total - w0), 32'd1);
        check("t2_b_count", 32'(b_hs_total - b0), 32'd1);
        check("t2_err", {31'd0, er}, 32'd0);
        check("t2_lat", 32'(lat), 32'd6);
        aw_delay = 0;

        // T2b: W delayed two cycles with an empty strobe
        w_delay = 2;
        aw0 = aw_hi_total; w0 = w_hi_total;
        do_req("t2b", 1'b1, 32'h20, 32'h1357_9BDF, 4'h0, 0, rd, er, lat, acc);
        check("t2b_aw_cycles", 32'(aw_hi_total - aw0), 32'd1);
        check("t2b_w_cycles", 32'(w_hi_total - w0), 32'd3);
        check("t2b_wstrb", {28'd0, last_wstrb}, 32'h0);
        check("t2b_wdata", last_wdata, 32'h1357_9BDF);
        check("t2b_lat", 32'(lat), 32'd5);
        w_delay = 0;

        // T3: unaligned read is word-aligned on AR
        rdata_k = 32'h0000_1234; rresp_k = 2'b00;
        r0 = r_hs_total;
        do_req("t3", 1'b0, 32'h0B, 32'h0, 4'h0, 0, rd, er, lat, acc);
        check("t3_araddr", last_araddr, 32'h08);
        check("t3_rdata", rd, 32'h0000_1234);
        check("t3_err", {31'd0, er}, 32'd0);
        check("t3_lat", 32'(lat), 32'd3);
        check("t3_r_count", 32'(r_hs_total - r0), 32'd1);

        // T4: SLVERR read, then clean write clears err and rdata
        rdata_k = 32'hDEAD_BEEF; rresp_k = 2'b10; ar_delay = 2;
        do_req("t4r", 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, acc);
        check("t4r_err", {31'd0, er}, 32'd1);
        check("t4r_rdata", rd, 32'hDEAD_BEEF);
        check("t4r_lat", 32'(lat), 32'd5);
        ar_delay = 0; rresp_k = 2'b00; bresp_k = 2'b00;
        do_req("t4w", 1'b1, 32'h44, 32'h5, 4'h1, 0, rd, er, lat, acc);
        check("t4w_err_rdata", {rd[30:0], er}, 32'd0);
        bresp_k = 2'b11;
        do_req("t4d", 1'b1, 32'h48, 32'h6, 4'hF, 0, rd, er, lat, acc);
        check("t4d_err", {31'd0, er}, 32'd1);
        bresp_k = 2'b00;

        // T5: response back-pressure for five cycles
        rdata_k = 32'hCAFE_F00D;
        do_req("t5", 1'b0, 32'h80, 32'h0, 4'h0, 5, rd, er, lat, acc);
        check("t5_rdata", rd, 32'hCAFE_F00D);

        // T6: reset while AW is stalled, then stray B beats in IDLE
        aw_delay = 20;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h100;
        i_req_wdata = 32'h77; i_req_wstrb = 4'hF;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        check("t6_aw_before_rst", {31'd0, m_axi_awvalid}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1 check("t6_valids_in_rst", {28'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, o_rsp_valid}, 32'd0);
        repeat (2) @(negedge i_clk);
        check("t6_valids_in_rst2", {28'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, o_rsp_valid}, 32'd0);
        #2 i_rst_n = 1'b1;
        aw_delay = 0;
        @(negedge i_clk);
        check("t6_req_ready", {31'd0, o_req_ready}, 32'd1);
        stray_b = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check("t6_stray_bready", {31'd0, m_axi_bready}, 32'd0);
        @(negedge i_clk);
        check("t6_stray_bready2", {30'd0, m_axi_bready, o_rsp_valid}, 32'd0);
        stray_b = 1'b0;
        @(negedge i_clk);
        b0 = b_hs_total;
        do_req("t6w", 1'b1, 32'h104, 32'h88, 4'hF, 0, rd, er, lat, acc);
        check("t6w_lat", 32'(lat), 32'd3);
        check("t6w_err", {31'd0, er}, 32'd0);
        check("t6w_b_count", 32'(b_hs_total - b0), 32'd1);
        check("t6w_awaddr", last_awaddr, 32'h104);

        check("protocol_stability", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
